// File: rtl/fclass_result_stage_if.sv
// fclass_result_stage_if
//   Handshake bus around the FCLASS writeback stage.
//   Upstream side : in_valid/in_ready with in_class (10-bit one-hot mask) and in_tag.
//   Downstream side: out_valid/out_ready with out_result (zero-extended mask) and out_tag.
//   master: the environment (drives inputs, consumes results)
//   slave : the stage itself
interface fclass_result_stage_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [9:0]       in_class;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_class, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_class, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/fclass_result_stage.sv
// fclass_result_stage
//   Registered writeback stage after float_classify. Holds up to two results
//   (main + skid entry) so a stalled consumer never causes a result to be lost,
//   and presents the class mask as a zero-extended integer result.
//   Ports:
//     clk, rst     clock (rising edge), asynchronous active-high reset
//     flush        synchronous discard of all buffered entries
//     bus          handshake bus (slave side): in_* upstream, out_* downstream
//     onehot_err   sticky flag: an accepted mask was not exactly one-hot
//     nan_count    saturating count of accepted masks with sNaN/qNaN bit set
module fclass_result_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    fclass_result_stage_if.slave   bus,
    output logic                   onehot_err,
    output logic [CNT_W-1:0]       nan_count
);
    logic             main_v, skid_v, rdy;
    logic [9:0]       main_class, skid_class;
    logic [TAG_W-1:0] main_tag, skid_tag;

    logic accept, drain;
    logic main_v_nx, skid_v_nx;
    logic load_main, load_skid, move;
    logic count_acc, not_onehot, is_nan;

    assign accept = bus.in_valid & rdy;
    assign drain  = main_v & bus.out_ready;

    assign bus.in_ready   = rdy;
    assign bus.out_valid  = main_v;
    assign bus.out_result = XLEN'(main_class);
    assign bus.out_tag    = main_tag;

    // Next-state of the two valid bits and which data register loads.
    always_comb begin
        main_v_nx = main_v;
        skid_v_nx = skid_v;
        load_main = 1'b0;
        load_skid = 1'b0;
        move      = 1'b0;
        if (flush) begin
            main_v_nx = 1'b0;
            skid_v_nx = 1'b0;
        end else if (skid_v) begin
            // rdy is low here, so no accept can coincide with the move
            if (drain) begin
                move      = 1'b1;
                skid_v_nx = 1'b0;
            end
        end else if (!main_v || drain) begin
            main_v_nx = accept;
            load_main = accept;
        end else if (accept) begin
            load_skid = 1'b1;
            skid_v_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v     <= 1'b0;
            skid_v     <= 1'b0;
            rdy        <= 1'b1;
            main_class <= '0;
            main_tag   <= '0;
            skid_class <= '0;
            skid_tag   <= '0;
        end else begin
            main_v <= main_v_nx;
            skid_v <= skid_v_nx;
            // Registered ready: only depends on whether the skid will hold data
            rdy    <= !skid_v_nx;
            if (load_main) begin
                main_class <= bus.in_class;
                main_tag   <= bus.in_tag;
            end else if (move) begin
                main_class <= skid_class;
                main_tag   <= skid_tag;
            end
            if (load_skid) begin
                skid_class <= bus.in_class;
                skid_tag   <= bus.in_tag;
            end
        end
    end

    // Debug status only counts accepts that survive (a flushed accept is dropped).
    assign count_acc  = accept & !flush;
    assign not_onehot = (bus.in_class == 10'd0) ||
                        ((bus.in_class & (bus.in_class - 10'd1)) != 10'd0);
    assign is_nan     = bus.in_class[8] | bus.in_class[9];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            onehot_err <= 1'b0;
            nan_count  <= '0;
        end else if (count_acc) begin
            if (not_onehot)
                onehot_err <= 1'b1;
            if (is_nan && (nan_count != {CNT_W{1'b1}}))
                nan_count <= nan_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_fclass_result_stage.sv
module tb_fclass_result_stage;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
    localparam int CNT_W = 2;

    logic clk, rst, flush, onehot_err;
    logic [CNT_W-1:0] nan_count;
    int n_cmp = 0;
    int n_bad = 0;

    fclass_result_stage_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    fclass_result_stage #(.XLEN(XLEN), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus.slave),
        .onehot_err(onehot_err), .nan_count(nan_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             v;
        logic [9:0]       cls;
        logic [TAG_W-1:0] tag;
        logic             ordy;
        logic             fl;
        logic             e_ov;
        logic [9:0]       e_res;
        logic [TAG_W-1:0] e_tag;
        logic             e_rdy;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive at the falling edge, then look at the result just after the rising edge.
    task automatic step(input logic v, input logic [9:0] cls, input logic [TAG_W-1:0] tag,
                        input logic ordy, input logic fl);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_class  = cls;
        bus.in_tag    = tag;
        bus.out_ready = ordy;
        flush         = fl;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic v, logic [9:0] cls, logic [TAG_W-1:0] tag, logic ordy,
                                logic fl, logic e_ov, logic [9:0] e_res,
                                logic [TAG_W-1:0] e_tag, logic e_rdy);
        vec_t r;
        r.v = v; r.cls = cls; r.tag = tag; r.ordy = ordy; r.fl = fl;
        r.e_ov = e_ov; r.e_res = e_res; r.e_tag = e_tag; r.e_rdy = e_rdy;
        return r;
    endfunction

    initial begin
        int sent, recv, cyc;
        logic [9:0] exp_cls;

        //          v  cls     tag ordy fl  ov  res     tag rdy
        vecs[0]  = mk(1, 10'h010, 3, 1, 0,  1, 10'h010, 3, 1); // one-cycle latency
        vecs[1]  = mk(0, 10'h000, 0, 0, 0,  1, 10'h010, 3, 1); // held while stalled
        vecs[2]  = mk(0, 10'h000, 0, 1, 0,  0, 10'h000, 0, 1); // drained
        vecs[3]  = mk(1, 10'h001, 1, 0, 0,  1, 10'h001, 1, 1);
        vecs[4]  = mk(1, 10'h080, 2, 0, 0,  1, 10'h001, 1, 0); // into skid
        vecs[5]  = mk(1, 10'h004, 7, 0, 0,  1, 10'h001, 1, 0); // refused (not ready)
        vecs[6]  = mk(0, 10'h000, 0, 1, 0,  1, 10'h080, 2, 1); // skid -> main
        vecs[7]  = mk(0, 10'h000, 0, 1, 0,  0, 10'h000, 0, 1);
        vecs[8]  = mk(1, 10'h002, 4, 1, 0,  1, 10'h002, 4, 1);
        vecs[9]  = mk(1, 10'h008, 5, 1, 0,  1, 10'h008, 5, 1); // drain + accept
        vecs[10] = mk(0, 10'h000, 0, 1, 0,  0, 10'h000, 0, 1);
        vecs[11] = mk(1, 10'h020, 6, 0, 1,  0, 10'h000, 0, 1); // flushed accept
        vecs[12] = mk(1, 10'h001, 1, 0, 0,  1, 10'h001, 1, 1);
        vecs[13] = mk(1, 10'h002, 2, 0, 0,  1, 10'h001, 1, 0); // both full
        vecs[14] = mk(0, 10'h000, 0, 0, 1,  0, 10'h000, 0, 1); // flush full stage

        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_class = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_result", bus.out_result, 32'd0);
        check("rst_out_tag", 32'(bus.out_tag), 32'd0);
        check("rst_onehot_err", 32'(onehot_err), 32'd0);
        check("rst_nan_count", 32'(nan_count), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].cls, vecs[i].tag, vecs[i].ordy, vecs[i].fl);
            check($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
            check($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_rdy));
            if (vecs[i].e_ov) begin
                check($sformatf("vec%0d_out_result", i), bus.out_result, 32'(vecs[i].e_res));
                check($sformatf("vec%0d_out_tag", i), 32'(bus.out_tag), 32'(vecs[i].e_tag));
            end
        end
        check("tbl_onehot_err", 32'(onehot_err), 32'd0);
        check("tbl_nan_count", 32'(nan_count), 32'd0);

        // NaN counter: a flushed accept does not count, then saturation at 3
        step(1, 10'h100, 1, 1, 1);
        check("nan_flushed", 32'(nan_count), 32'd0);
        for (int k = 0; k < 5; k++) begin
            step(1, 10'h200, 5'(k), 1, 0);
            check($sformatf("nan_cnt%0d", k), 32'(nan_count), (k < 3) ? 32'(k + 1) : 32'd3);
        end
        step(1, 10'h100, 9, 1, 1);
        check("nan_flushed_sat", 32'(nan_count), 32'd3);
        step(0, 10'h000, 0, 1, 0);

        // Sticky one-hot error
        step(1, 10'h003, 1, 1, 0);
        check("err_after_003", 32'(onehot_err), 32'd1);
        step(1, 10'h000, 2, 1, 0);
        check("err_after_000", 32'(onehot_err), 32'd1);
        step(0, 10'h000, 0, 1, 1);
        check("err_after_flush", 32'(onehot_err), 32'd1);
        step(1, 10'h004, 3, 1, 0);
        check("err_after_valid", 32'(onehot_err), 32'd1);
        step(0, 10'h000, 0, 1, 0);

        // Stream 20 inputs with out_ready toggling every cycle
        sent = 0; recv = 0; cyc = 0;
        while (recv < 20 && cyc < 200) begin
            @(negedge clk);
            bus.in_valid  = (sent < 20);
            bus.in_class  = 10'(1 << (sent % 8));
            bus.in_tag    = TAG_W'(sent);
            bus.out_ready = cyc[0];
            flush         = 1'b0;
            #4;
            if (!bus.in_ready)
                check("stream_ready_low_only_when_full", 32'(bus.out_valid), 32'd1);
            if (bus.out_valid && bus.out_ready) begin
                exp_cls = 10'(1 << (recv % 8));
                check($sformatf("stream%0d_result", recv), bus.out_result, 32'(exp_cls));
                check($sformatf("stream%0d_tag", recv), 32'(bus.out_tag), 32'(recv));
                recv++;
            end
            if (bus.in_valid && bus.in_ready)
                sent++;
            cyc++;
        end
        check("stream_received", 32'(recv), 32'd20);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check("stream_no_extra", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset with both entries full
        step(1, 10'h001, 1, 0, 0);
        step(1, 10'h200, 2, 0, 0);
        check("pre_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("pre_rst_nan", 32'(nan_count), 32'd3);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        check("arst_out_result", bus.out_result, 32'd0);
        check("arst_out_tag", 32'(bus.out_tag), 32'd0);
        check("arst_onehot_err", 32'(onehot_err), 32'd0);
        check("arst_nan_count", 32'(nan_count), 32'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
